// File: rtl/pipeline_hazard_controller.sv
// Hazard/redirect sequencer for a five-stage pipeline with no forwarding.
// A shadow scoreboard of in-flight destinations drives stalls, bubbles and squashes.
module pipeline_hazard_controller #(
   parameter bit WB_HAZARD = 1'b0,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 id_valid,
   input  logic [4:0]           id_rs,
   input  logic [4:0]           id_rt,
   input  logic                 id_uses_rs,
   input  logic                 id_uses_rt,
   input  logic                 id_regwrite,
   input  logic [4:0]           id_dest,
   input  logic                 mem_redirect,
   output logic                 pc_enable,
   output logic                 ifid_enable,
   output logic                 ifid_flush,
   output logic                 idex_bubble,
   output logic                 exmem_bubble,
   output logic                 stalled,
   output logic [CNT_WIDTH-1:0] stall_count,
   output logic [CNT_WIDTH-1:0] flush_count
);

   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
   } sbEntry_t;

   typedef enum logic {RUN, STALL} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   sbEntry_t sbEx, sbMem, sbWb, newEntry;
   state_t   state, stateNext;
   logic     matchRs, matchRt, hazard;

   function automatic logic hit(input sbEntry_t e, input logic [4:0] r);
      return e.valid && (e.dest == r) && (r != 5'd0);
   endfunction

   // The WB slot only matters when the register file cannot forward a same-cycle write.
   assign matchRs = hit(sbEx, id_rs) || hit(sbMem, id_rs) || (WB_HAZARD && hit(sbWb, id_rs));
   assign matchRt = hit(sbEx, id_rt) || hit(sbMem, id_rt) || (WB_HAZARD && hit(sbWb, id_rt));
   assign hazard  = id_valid && ((id_uses_rs && matchRs) || (id_uses_rt && matchRt));

   assign newEntry.valid = id_valid && id_regwrite && (id_dest != 5'd0);
   assign newEntry.dest  = id_dest;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sbEx  <= '0;
         sbMem <= '0;
         sbWb  <= '0;
      end else begin
         sbWb <= sbMem;
         if (mem_redirect) begin
            sbMem <= '0;
            sbEx  <= '0;
         end else if (hazard) begin
            sbMem <= sbEx;
            sbEx  <= '0;
         end else begin
            sbMem <= sbEx;
            sbEx  <= newEntry;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= RUN;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         RUN:     if (hazard && !mem_redirect) stateNext = STALL;
         STALL:   if (mem_redirect || !hazard) stateNext = RUN;
         default: stateNext = RUN;
      endcase
   end

   assign stalled = (state == STALL);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (hazard && !mem_redirect && (stall_count != CNT_MAX))
            stall_count <= stall_count + CNT_WIDTH'(1);
         if (mem_redirect && (flush_count != CNT_MAX))
            flush_count <= flush_count + CNT_WIDTH'(1);
      end
   end

   // While reset is held the pipeline is frozen and filled with bubbles.
   always_comb begin
      pc_enable    = 1'b0;
      ifid_enable  = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      if (reset) begin
         pc_enable    = !hazard || mem_redirect;
         ifid_enable  = !hazard || mem_redirect;
         ifid_flush   = mem_redirect;
         idex_bubble  = hazard || mem_redirect;
         exmem_bubble = mem_redirect;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: three configurations share one stimulus
// stream and are checked against an in-flight destination list model.
module tb_pipeline_hazard_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_uses_rs, id_uses_rt, id_regwrite, mem_redirect;
   logic [4:0] id_rs, id_rt, id_dest;

   logic       pcEn[3], ifidEn[3], ifidFl[3], idexBub[3], exBub[3], stl[3];
   logic [15:0] sc0, fc0, sc1, fc1;
   logic [3:0]  sc2, fc2;

   int nChecks = 0;
   int nFails  = 0;

   // Model: per instance, destinations in EX/MEM/WB (0 = nothing tracked)
   int mDest[3][3];
   bit mStall[3];
   int mSc[3], mFc[3];
   int satMax[3] = '{65535, 65535, 15};
   bit wbH[3]    = '{1'b0, 1'b1, 1'b0};

   always #5 clk = ~clk;

   pipeline_hazard_controller #(.WB_HAZARD(1'b0), .CNT_WIDTH(16)) u0 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
      .id_dest(id_dest), .mem_redirect(mem_redirect), .pc_enable(pcEn[0]),
      .ifid_enable(ifidEn[0]), .ifid_flush(ifidFl[0]), .idex_bubble(idexBub[0]),
      .exmem_bubble(exBub[0]), .stalled(stl[0]), .stall_count(sc0), .flush_count(fc0));

   pipeline_hazard_controller #(.WB_HAZARD(1'b1), .CNT_WIDTH(16)) u1 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
      .id_dest(id_dest), .mem_redirect(mem_redirect), .pc_enable(pcEn[1]),
      .ifid_enable(ifidEn[1]), .ifid_flush(ifidFl[1]), .idex_bubble(idexBub[1]),
      .exmem_bubble(exBub[1]), .stalled(stl[1]), .stall_count(sc1), .flush_count(fc1));

   pipeline_hazard_controller #(.WB_HAZARD(1'b0), .CNT_WIDTH(4)) u2 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
      .id_dest(id_dest), .mem_redirect(mem_redirect), .pc_enable(pcEn[2]),
      .ifid_enable(ifidEn[2]), .ifid_flush(ifidFl[2]), .idex_bubble(idexBub[2]),
      .exmem_bubble(exBub[2]), .stalled(stl[2]), .stall_count(sc2), .flush_count(fc2));

   function automatic int actSc(int k);
      if (k == 0) return int'(sc0);
      if (k == 1) return int'(sc1);
      return int'(sc2);
   endfunction

   function automatic int actFc(int k);
      if (k == 0) return int'(fc0);
      if (k == 1) return int'(fc1);
      return int'(fc2);
   endfunction

   // A read is blocked while its register is still in flight in a checked stage.
   function automatic bit mHaz(int k);
      int depth = wbH[k] ? 3 : 2;
      if (!id_valid) return 1'b0;
      for (int i = 0; i < depth; i++) begin
         if (mDest[k][i] != 0) begin
            if (id_uses_rs && int'(id_rs) == mDest[k][i]) return 1'b1;
            if (id_uses_rt && int'(id_rt) == mDest[k][i]) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic logic [4:0] expComb(int k);
      bit h;
      if (!reset) return 5'b00111;
      h = mHaz(k);
      return {!h || mem_redirect, !h || mem_redirect, mem_redirect, h || mem_redirect, mem_redirect};
   endfunction

   task automatic modelReset();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 3; i++) mDest[k][i] = 0;
         mStall[k] = 1'b0;
         mSc[k] = 0;
         mFc[k] = 0;
      end
   endtask

   task automatic advance();
      for (int k = 0; k < 3; k++) begin
         if (!reset) begin
            for (int i = 0; i < 3; i++) mDest[k][i] = 0;
            mStall[k] = 1'b0; mSc[k] = 0; mFc[k] = 0;
         end else begin
            bit h = mHaz(k);
            int nd = (id_valid && id_regwrite) ? int'(id_dest) : 0;
            mDest[k][2] = mDest[k][1];
            if (mem_redirect) begin
               mDest[k][1] = 0; mDest[k][0] = 0;
               if (mFc[k] < satMax[k]) mFc[k]++;
            end else if (h) begin
               mDest[k][1] = mDest[k][0]; mDest[k][0] = 0;
               if (mSc[k] < satMax[k]) mSc[k]++;
            end else begin
               mDest[k][1] = mDest[k][0]; mDest[k][0] = nd;
            end
            mStall[k] = h && !mem_redirect;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic setIn(bit v, int rs, int rt, bit urs, bit urt, bit rw, int d, bit red);
      id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt);
      id_uses_rs = urs; id_uses_rt = urt; id_regwrite = rw;
      id_dest = 5'(d); mem_redirect = red;
   endtask

   task automatic doReset();
      reset = 1'b0;
      modelReset();
      setIn(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      setIn(1, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      modelReset();
      for (int c = 0; c < 3; c++) begin
         #2;
         for (int k = 0; k < 3; k++) begin
            nChecks++;
            if ({pcEn[k], ifidEn[k], ifidFl[k], idexBub[k], exBub[k]} !== 5'b00111 ||
                actSc(k) != 0 || actFc(k) != 0) begin
               nFails++;
               $display("FAIL reset_hold inst%0d cyc%0d got ctl=%b sc=%0d fc=%0d exp ctl=00111 sc=0 fc=0",
                        k, c, {pcEn[k], ifidEn[k], ifidFl[k], idexBub[k], exBub[k]}, actSc(k), actFc(k));
            end
         end
         @(posedge clk); #1;
      end
      reset = 1'b1;
      #2;
      nChecks++;
      if (pcEn[0] !== 1'b1 || stl[0] !== 1'b0) begin
         nFails++;
         $display("FAIL reset_release got pc_enable=%b stalled=%b exp 1 0", pcEn[0], stl[0]);
      end
      advance();
   endtask

   task automatic test_back_to_back();
      int pc0[3], bub[3], st[3];
      doReset();
      setIn(1, 0, 0, 1, 0, 1, 8, 0);   // addi $8,$0,imm
      #2;
      nChecks++;
      if (pcEn[0] !== 1'b1) begin
         nFails++;
         $display("FAIL raw_producer got pc_enable=%b exp 1", pcEn[0]);
      end
      advance();
      setIn(1, 8, 8, 1, 1, 1, 9, 0);   // add $9,$8,$8
      for (int k = 0; k < 3; k++) begin pc0[k] = 0; bub[k] = 0; st[k] = 0; end
      repeat (5) begin
         #2;
         for (int k = 0; k < 3; k++) begin
            if (pcEn[k] === 1'b0) pc0[k]++;
            if (idexBub[k] === 1'b1) bub[k]++;
            if (stl[k] === 1'b1) st[k]++;
         end
         advance();
      end
      for (int k = 0; k < 3; k++) begin
         int exp = wbH[k] ? 3 : 2;
         nChecks++;
         if (pc0[k] != exp || bub[k] != exp || st[k] != exp || actSc(k) != exp) begin
            nFails++;
            $display("FAIL raw_stall inst%0d got pc0=%0d bubbles=%0d stalled=%0d sc=%0d exp all %0d",
                     k, pc0[k], bub[k], st[k], actSc(k), exp);
         end
      end
   endtask

   task automatic test_zero_dest();
      doReset();
      setIn(1, 0, 0, 1, 0, 1, 0, 0);   // addi $0,$0,imm
      advance();
      setIn(1, 0, 0, 1, 1, 1, 9, 0);   // add $9,$0,$0
      repeat (3) begin
         #2;
         for (int k = 0; k < 3; k++) begin
            nChecks++;
            if (pcEn[k] !== 1'b1 || idexBub[k] !== 1'b0) begin
               nFails++;
               $display("FAIL zero_dest inst%0d got pc_enable=%b idex_bubble=%b exp 1 0",
                        k, pcEn[k], idexBub[k]);
            end
         end
         advance();
      end
      nChecks++;
      if (actSc(0) != 0 || actSc(1) != 0) begin
         nFails++;
         $display("FAIL zero_dest_count got sc0=%0d sc1=%0d exp 0 0", actSc(0), actSc(1));
      end
   endtask

   task automatic test_redirect_in_stall();
      doReset();
      setIn(1, 0, 0, 1, 0, 1, 8, 0);
      advance();
      setIn(1, 8, 8, 1, 1, 1, 9, 0);
      #2;
      nChecks++;
      if (pcEn[0] !== 1'b0) begin
         nFails++;
         $display("FAIL redir_pre got pc_enable=%b exp 0", pcEn[0]);
      end
      advance();
      mem_redirect = 1'b1;
      #2;
      nChecks++;
      if ({pcEn[0], ifidEn[0], ifidFl[0], idexBub[0], exBub[0]} !== 5'b11111) begin
         nFails++;
         $display("FAIL redir_comb got %b exp 11111", {pcEn[0], ifidEn[0], ifidFl[0], idexBub[0], exBub[0]});
      end
      advance();
      setIn(1, 8, 0, 1, 0, 0, 0, 0);   // reads $8 only
      #2;
      nChecks++;
      if (stl[0] !== 1'b0 || stl[1] !== 1'b0 || actFc(0) != 1 || actSc(0) != 1) begin
         nFails++;
         $display("FAIL redir_after got stalled=%b/%b fc=%0d sc=%0d exp 0/0 1 1", stl[0], stl[1], actFc(0), actSc(0));
      end
      nChecks++;
      if (pcEn[0] !== 1'b1 || pcEn[1] !== 1'b0) begin
         nFails++;
         $display("FAIL redir_scoreboard got pc_enable wb0=%b wb1=%b exp 1 0", pcEn[0], pcEn[1]);
      end
      advance();
   endtask

   task automatic test_reset_midstall();
      doReset();
      setIn(1, 0, 0, 1, 0, 1, 8, 0);
      advance();
      setIn(1, 8, 8, 1, 1, 1, 9, 0);
      advance();
      #2;
      nChecks++;
      if (stl[0] !== 1'b1) begin
         nFails++;
         $display("FAIL midstall_pre got stalled=%b exp 1", stl[0]);
      end
      reset = 1'b0;
      modelReset();
      #1;
      nChecks++;
      if (stl[0] !== 1'b0 || pcEn[0] !== 1'b0 || idexBub[0] !== 1'b1) begin
         nFails++;
         $display("FAIL midstall_async got stalled=%b pc=%b bub=%b exp 0 0 1", stl[0], pcEn[0], idexBub[0]);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      #2;
      for (int k = 0; k < 3; k++) begin
         nChecks++;
         if (pcEn[k] !== 1'b1 || stl[k] !== 1'b0 || actSc(k) != 0) begin
            nFails++;
            $display("FAIL midstall_resume inst%0d got pc=%b stalled=%b sc=%0d exp 1 0 0",
                     k, pcEn[k], stl[k], actSc(k));
         end
      end
      advance();
   endtask

   task automatic test_saturation();
      int cyc = 0;
      doReset();
      setIn(1, 8, 8, 1, 1, 1, 8, 0);   // add $8,$8,$8 repeatedly
      while (mSc[0] < 20 && cyc < 100) begin
         advance();
         cyc++;
      end
      #2;
      nChecks++;
      if (cyc >= 100) begin
         nFails++;
         $display("FAIL sat_timeout got model stalls=%0d exp 20", mSc[0]);
      end
      nChecks++;
      if (actSc(2) != 15 || actSc(0) != 20) begin
         nFails++;
         $display("FAIL sat_count got sc4bit=%0d sc16bit=%0d exp 15 20", actSc(2), actSc(0));
      end
      advance();
   endtask

   task automatic test_random();
      doReset();
      for (int c = 0; c < 400; c++) begin
         setIn($urandom % 4 != 0, $urandom % 4, $urandom % 4, 1'($urandom), 1'($urandom),
               1'($urandom), $urandom % 4, $urandom % 8 == 0);
         #2;
         for (int k = 0; k < 3; k++) begin
            logic [4:0] e = expComb(k);
            logic [4:0] a = {pcEn[k], ifidEn[k], ifidFl[k], idexBub[k], exBub[k]};
            nChecks++;
            if (a !== e) begin
               nFails++;
               $display("FAIL rand_comb inst%0d cyc%0d got %b exp %b", k, c, a, e);
            end
            nChecks++;
            if (stl[k] !== mStall[k]) begin
               nFails++;
               $display("FAIL rand_stalled inst%0d cyc%0d got %b exp %b", k, c, stl[k], mStall[k]);
            end
            nChecks++;
            if (actSc(k) != mSc[k] || actFc(k) != mFc[k]) begin
               nFails++;
               $display("FAIL rand_counts inst%0d cyc%0d got sc=%0d fc=%0d exp sc=%0d fc=%0d",
                        k, c, actSc(k), actFc(k), mSc[k], mFc[k]);
            end
         end
         advance();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      modelReset();
      setIn(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      test_reset();
      test_back_to_back();
      test_zero_dest();
      test_redirect_in_stall();
      test_reset_midstall();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the five-stage MIPS pipeline (IF, IFID, IDEX, EXMEM, MEMWB), which has no forwarding path.
- Holds a 3-entry destination scoreboard shadowing the EX, MEM and WB stages.
- Stalls PC and IFID and injects IDEX bubbles on RAW hazards.
- Squashes wrong-path instructions when a branch, jump or jr resolves in the MEM stage. Also keeps saturating stall and flush performance counters.

Parameters:
- WB_HAZARD, 0, 1 = also treat a match against the WB-stage destination as a hazard (register file not write-before-read).
- CNT_WIDTH, 16, width of the stall_count and flush_count performance counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_valid  input  1  the IFID register holds a real (non-bubble) instruction.
- id_rs  input  5  Rs field, IFID instruction [25:21].
- id_rt  input  5  Rt field, IFID instruction [20:16].
- id_uses_rs  input  1  the decoded instruction reads Rs.
- id_uses_rt  input  1  the decoded instruction reads Rt (R-type, beq/bne, sw).
- id_regwrite  input  1  the decoded instruction writes a register.
- id_dest  input  5  the decoded instruction's final destination (rd, rt or 31 for jal).
- mem_redirect  input  1  the PC mux selects a non-sequential source this cycle (taken branch, jump or jr in EXMEM).
- pc_enable  output  1  PC register load enable.
- ifid_enable  output  1  IFID register load enable.
- ifid_flush  output  1  load a NOP into IFID on this edge.
- idex_bubble  output  1  load zeroed control signals into IDEX on this edge.
- exmem_bubble  output  1  load zeroed control signals into EXMEM on this edge.
- stalled  output  1  registered; FSM is in STALL.
- stall_count  output  CNT_WIDTH  saturating count of stall cycles.
- flush_count  output  CNT_WIDTH  saturating count of redirects.

Behaviour:
- Scoreboard: entries sb_ex, sb_mem, sb_wb, each holding {valid, dest[4:0]}. An entry is valid only if dest != 0.
- match(r) = r != 0 and (sb_ex.valid and sb_ex.dest == r, or sb_mem.valid and sb_mem.dest == r, or [WB_HAZARD] sb_wb.valid and sb_wb.dest == r).
- hazard = id_valid and ((id_uses_rs and match(id_rs)) or (id_uses_rt and match(id_rt))). Combinational.
- Priority: redirect > hazard > normal flow.
- Combinational outputs while reset is high:
  - pc_enable = ifid_enable = !hazard or mem_redirect
  - ifid_flush = mem_redirect
  - idex_bubble = hazard or mem_redirect
  - exmem_bubble = mem_redirect
- Scoreboard update at the clock edge:
  - redirect: sb_wb <= sb_mem; sb_mem <= invalid; sb_ex <= invalid.
  - hazard (no redirect): sb_wb <= sb_mem; sb_mem <= sb_ex; sb_ex <= invalid.
  - normal: shift, and sb_ex <= {id_valid and id_regwrite and id_dest != 0, id_dest}.
- FSM, two states:
  - RUN: hazard and !mem_redirect -> STALL; otherwise stay in RUN.
  - STALL: mem_redirect or !hazard -> RUN; otherwise stay in STALL.
  - stalled = (state == STALL).
- Stall latency: the longest hazard stall is 2 cycles (3 cycles with WB_HAZARD = 1). A dependent instruction issues on the first edge after the producer leaves the checked stages.
- Counters:
  - stall_count increments on every edge where hazard and !mem_redirect.
  - flush_count increments on every edge where mem_redirect.
  - Both saturate at all-ones and never wrap.
- Reset (reset low, asynchronous):
  - Scoreboard all invalid, state RUN, counters 0, stalled 0.
  - Combinational outputs forced: pc_enable = 0, ifid_enable = 0, ifid_flush = 1, idex_bubble = 1, exmem_bubble = 1.
- Reset released mid-stall: the pipeline resumes from an empty scoreboard in RUN; no stale hazard is reported.
- Register 0 never produces a hazard, regardless of the id_dest written.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with id_valid = 1 -> pc_enable = 0, ifid_flush = 1, idex_bubble = 1, exmem_bubble = 1, counters = 0. Release reset -> pc_enable = 1 and stalled = 0 on the next cycle.
- Back-to-back RAW: addi $8 issued, then add $9,$8,$8 (uses_rs = uses_rt = 1) with WB_HAZARD = 0 -> exactly 2 cycles of pc_enable = 0 and idex_bubble = 1, stalled = 1 for those 2 cycles, stall_count = 2.
- Same RAW sequence with WB_HAZARD = 1 -> 3 stall cycles, stall_count = 3.
- $zero destination: addi $0 followed by add $9,$0,$0 -> no stall, pc_enable stays 1.
- Redirect during stall: RAW stall active and mem_redirect = 1 in the same cycle -> pc_enable = 1, ifid_flush = 1, idex_bubble = 1, exmem_bubble = 1. Next cycle sb_ex and sb_mem are invalid, state is RUN, flush_count = 1, stall_count unchanged.
- Saturation: CNT_WIDTH = 4, force 20 consecutive stall cycles -> stall_count holds at 15 with no wrap.
